// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data memory arbiter between the CPU load/store port and a full-memory dump engine
//
// Ports:
//   clk, reset (async, active-low)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  -> CPU request (byte address, word = cpu_addr[AW+2:3])
//   cpu_gnt (comb), cpu_rvalid/cpu_rdata  <- grant and read return
//   dump_start                         -> begin a full-memory dump (ignored unless idle)
//   dump_busy/dump_done                <- dump status
//   dump_valid/dump_ready/dump_addr/dump_data <-> dump output stream (2-entry FIFO head)
//   mem_addr/mem_we/mem_re/mem_wdata   <- single-port memory request
//   mem_rdata                          -> memory read data, one cycle after mem_re
module dmem_arbiter #(
    parameter int N        = 64,
    parameter int AW       = 6,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [N-1:0]  cpu_addr,
    input  logic [N-1:0]  cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [N-1:0]  cpu_rdata,
    input  logic          dump_start,
    output logic          dump_busy,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic [AW-1:0] dump_addr,
    output logic [N-1:0]  dump_data,
    output logic          dump_done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic          mem_re,
    output logic [N-1:0]  mem_wdata,
    input  logic [N-1:0]  mem_rdata
);

    localparam int DEPTH = 2 ** AW;
    localparam int WW    = $clog2(MAX_WAIT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    state;
    logic [AW-1:0] ptr;
    logic [WW-1:0] wait_cnt;

    logic [AW-1:0] fifo_addr [2];
    logic [N-1:0]  fifo_data [2];
    logic          wr_idx;
    logic          rd_idx;
    logic [1:0]    count;

    // One-cycle tag describing the read that returns on mem_rdata this cycle.
    logic          tag_dump;
    logic          tag_cpu;
    logic [AW-1:0] tag_addr;

    logic eligible;
    logic dump_win;
    logic cpu_win;
    logic push;
    logic pop;
    logic last_issue;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[N-1:AW+3], cpu_addr[2:0]};

    // Counting the in-flight dump read keeps FIFO occupancy bounded at 2
    // even though its data has not landed yet.
    assign eligible   = (state == S_RUN) && ((count + {1'b0, tag_dump}) < 2'd2);
    assign dump_win   = reset && eligible && (!cpu_req || (wait_cnt == WW'(MAX_WAIT)));
    assign cpu_win    = reset && cpu_req && !dump_win;
    assign last_issue = dump_win && (ptr == AW'(DEPTH - 1));

    assign push = tag_dump;
    assign pop  = (count != 2'd0) && dump_ready;

    assign cpu_gnt    = cpu_win;
    assign cpu_rvalid = tag_cpu;
    assign cpu_rdata  = tag_cpu ? mem_rdata : '0;

    assign dump_busy  = (state != S_IDLE);
    assign dump_valid = (count != 2'd0);
    assign dump_addr  = fifo_addr[rd_idx];
    assign dump_data  = fifo_data[rd_idx];
    assign dump_done  = (state == S_DRAIN) && (count == 2'd0) && !tag_dump;

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_wdata = '0;
        if (dump_win) begin
            mem_addr = ptr;
            mem_re   = 1'b1;
        end else if (cpu_win) begin
            mem_addr  = cpu_addr[AW+2:3];
            mem_we    = cpu_we;
            mem_re    = !cpu_we;
            mem_wdata = cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            ptr      <= '0;
            wait_cnt <= '0;
            wr_idx   <= 1'b0;
            rd_idx   <= 1'b0;
            count    <= 2'd0;
            tag_dump <= 1'b0;
            tag_cpu  <= 1'b0;
            tag_addr <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_addr[i] <= '0;
                fifo_data[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (dump_start) begin
                        state <= S_RUN;
                        ptr   <= '0;
                    end
                end
                S_RUN: begin
                    if (last_issue) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (dump_done) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (dump_win) begin
                ptr <= ptr + 1'b1;
            end

            if (eligible && !dump_win) begin
                if (wait_cnt != WW'(MAX_WAIT)) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end

            tag_dump <= dump_win;
            tag_cpu  <= cpu_win && !cpu_we;
            tag_addr <= ptr;

            if (push) begin
                fifo_addr[wr_idx] <= tag_addr;
                fifo_data[wr_idx] <= mem_rdata;
                wr_idx            <= !wr_idx;
            end
            if (pop) begin
                rd_idx <= !rd_idx;
            end

            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
